timer_multi: RTL and testbench

- Next-generation timer core: a free-running 2*DATA_W time base with programmable prescaler, sample register and sync clear.
- Adds N_CH independent down-count channels, each one-shot or periodic, with sticky interrupt-pending flags, a per-channel mask and a combined IRQ.
- Sits behind the peripheral register bank; the bank drives the command/config inputs and reads status.

---
 rtl/timer_multi.sv | 163 ++++++++++++++++
 tb/tb_timer_multi.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : timer_multi
// Purpose  : Prescaled 2*DATA_W time base with sample/wrap plus N_CH
//            independent one-shot/periodic down-count channels and IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module timer_multi #(
    parameter int DATA_W  = 32,
    parameter int N_CH    = 4,
    parameter int PRESC_W = 16,
    parameter int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  TIMER_ENABLE,
    input  logic                  TIMER_CLEAR,
    input  logic                  TIMER_SAMPLE,
    input  logic [PRESC_W-1:0]    PRESCALE,
    output logic [2*DATA_W-1:0]   TIMER_VALUE,
    output logic                  TIMER_WRAP,
    input  logic [1:0]            CH_CMD,
    input  logic [SEL_W-1:0]      CH_SEL,
    input  logic [DATA_W-1:0]     CH_LOAD,
    input  logic                  CH_PERIODIC,
    input  logic [N_CH-1:0]       IRQ_MASK,
    output logic [N_CH-1:0]       CH_ACTIVE,
    output logic [N_CH-1:0]       IRQ_PEND,
    output logic                  IRQ
);

    localparam int         TB_W      = 2 * DATA_W;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;
    localparam logic [1:0] CMD_CLR   = 2'b11;

    typedef enum logic [0:0] {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [TB_W-1:0]    time_base_q, time_base_d;
    logic [TB_W-1:0]    sample_q, sample_d;
    logic               wrap_q, wrap_d;
    logic               tick;
    logic [N_CH-1:0]    active_vec;
    logic [N_CH-1:0]    pend_vec;

    // Equality compare: a PRESCALE lowered under the count runs through wrap.
    always_comb begin
        tick        = TIMER_ENABLE && !TIMER_CLEAR && (presc_cnt_q == PRESCALE);
        presc_cnt_d = presc_cnt_q;
        time_base_d = time_base_q;
        wrap_d      = wrap_q;
        sample_d    = sample_q;
        if (TIMER_SAMPLE) begin
            sample_d = time_base_q;
        end
        if (TIMER_CLEAR) begin
            presc_cnt_d = '0;
            time_base_d = '0;
            wrap_d      = 1'b0;
        end else begin
            if (TIMER_ENABLE) begin
                presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
            end
            if (tick) begin
                time_base_d = time_base_q + 1'b1;
                if (&time_base_q) begin
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q <= '0;
            time_base_q <= '0;
            sample_q    <= '0;
            wrap_q      <= 1'b0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            time_base_q <= time_base_d;
            sample_q    <= sample_d;
            wrap_q      <= wrap_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_state_e         state_q, state_d;
        logic [DATA_W-1:0] cnt_q, cnt_d;
        logic [DATA_W-1:0] reload_q, reload_d;
        logic              mode_q, mode_d;
        logic              pend_q, pend_d;
        logic              hit;
        logic              expire;

        assign hit = (CH_SEL == SEL_W'(i));

        // A start/stop on this channel masks the same-cycle tick.
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            reload_d = reload_q;
            mode_d   = mode_q;
            pend_d   = pend_q;
            expire   = 1'b0;
            if (hit && CH_CMD == CMD_START) begin
                cnt_d    = CH_LOAD;
                reload_d = CH_LOAD;
                mode_d   = CH_PERIODIC;
                state_d  = CH_RUN;
            end else if (hit && CH_CMD == CMD_STOP) begin
                state_d = CH_IDLE;
            end else if (state_q == CH_RUN && tick) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    expire = 1'b1;
                    if (mode_q) begin
                        cnt_d = reload_q;
                    end else begin
                        state_d = CH_IDLE;
                    end
                end
            end
            if (expire) begin
                pend_d = 1'b1;
            end else if (hit && CH_CMD == CMD_CLR) begin
                pend_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= CH_IDLE;
                cnt_q    <= '0;
                reload_q <= '0;
                mode_q   <= 1'b0;
                pend_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                reload_q <= reload_d;
                mode_q   <= mode_d;
                pend_q   <= pend_d;
            end
        end

        assign active_vec[i] = (state_q == CH_RUN);
        assign pend_vec[i]   = pend_q;
    end

    assign TIMER_VALUE = sample_q;
    assign TIMER_WRAP  = wrap_q;
    assign CH_ACTIVE   = active_vec;
    assign IRQ_PEND    = pend_vec;
    assign IRQ         = |(pend_vec & IRQ_MASK);

endmodule
`default_nettype wire

// File: tb/tb_timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_multi
// Purpose  : Scoreboard bench for timer_multi against a tick-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_multi;

    localparam int DW  = 4;
    localparam int NC  = 3;
    localparam int PW  = 4;
    localparam int SW  = 2;
    localparam int TBW = 2 * DW;

    localparam logic [1:0] C_START = 2'b01;
    localparam logic [1:0] C_STOP  = 2'b10;
    localparam logic [1:0] C_CLR   = 2'b11;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0, clr = 1'b0, smp = 1'b0;
    logic [PW-1:0]   presc = '0;
    logic [1:0]      cmd = '0;
    logic [SW-1:0]   sel = '0;
    logic [DW-1:0]   load = '0;
    logic            per = 1'b0;
    logic [NC-1:0]   mask = '0;
    logic [TBW-1:0]  tv;
    logic            wrap;
    logic [NC-1:0]   act, pend;
    logic            irq;

    timer_multi #(.DATA_W(DW), .N_CH(NC), .PRESC_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .TIMER_ENABLE(en), .TIMER_CLEAR(clr), .TIMER_SAMPLE(smp),
        .PRESCALE(presc), .TIMER_VALUE(tv), .TIMER_WRAP(wrap),
        .CH_CMD(cmd), .CH_SEL(sel), .CH_LOAD(load), .CH_PERIODIC(per),
        .IRQ_MASK(mask), .CH_ACTIVE(act), .IRQ_PEND(pend), .IRQ(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TBW-1:0] tv;
        logic           wrap;
        logic [NC-1:0]  act;
        logic [NC-1:0]  pend;
        logic           irq;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model: each channel tracks ticks left until it expires.
    int m_presc, m_tb, m_sample, m_wrap;
    int m_act[NC], m_left[NC], m_rel[NC], m_per[NC], m_pend[NC];

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_presc = 0; m_tb = 0; m_sample = 0; m_wrap = 0;
        for (int i = 0; i < NC; i++) begin
            m_act[i] = 0; m_left[i] = 0; m_rel[i] = 0; m_per[i] = 0; m_pend[i] = 0;
        end
    endtask

    task automatic model_step();
        bit   tk;
        bit   hit, expired;
        exp_t e;
        tk = en && !clr && (m_presc == int'(presc));
        if (clr) m_presc = 0;
        else if (en) m_presc = tk ? 0 : (m_presc + 1) % (1 << PW);
        if (smp) m_sample = m_tb;
        if (clr) begin
            m_tb = 0; m_wrap = 0;
        end else if (tk) begin
            m_tb = (m_tb + 1) % (1 << TBW);
            if (m_tb == 0) m_wrap = 1;
        end
        for (int i = 0; i < NC; i++) begin
            hit = (int'(sel) == i);
            expired = 0;
            if (hit && cmd == C_START) begin
                m_act[i] = 1; m_left[i] = int'(load) + 1; m_rel[i] = int'(load); m_per[i] = per;
            end else if (hit && cmd == C_STOP) begin
                m_act[i] = 0;
            end else if (m_act[i] != 0 && tk) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    expired = 1;
                    if (m_per[i] != 0) m_left[i] = m_rel[i] + 1;
                    else m_act[i] = 0;
                end
            end
            if (expired) m_pend[i] = 1;
            else if (hit && cmd == C_CLR) m_pend[i] = 0;
        end
        e.tv   = TBW'(m_sample);
        e.wrap = (m_wrap != 0);
        for (int i = 0; i < NC; i++) begin
            e.act[i]  = (m_act[i] != 0);
            e.pend[i] = (m_pend[i] != 0);
        end
        e.irq = |(e.pend & mask);
        q.push_back(e);
    endtask

    // One clock: expectation for the current inputs, then past the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        cmd = '0; smp = 1'b0; clr = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic cmd1(input logic [1:0] c, input int s, input int l, input logic p);
        cmd = c; sel = SW'(s); load = DW'(l); per = p;
        cycle();
        cmd = '0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("timer_value", tv, e.tv);
                chk("timer_wrap", wrap, e.wrap);
                chk("ch_active", act, e.act);
                chk("irq_pend", pend, e.pend);
                chk("irq", irq, e.irq);
            end
        end
    end

    initial begin : driver
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_value", tv, 0);
        chk("rst_active", act, 0);
        chk("rst_pend", pend, 0);
        rst_n = 1'b1;

        // Time base and prescaler
        en = 1'b1; presc = '0;
        run(10);
        smp = 1'b1; en = 1'b0; cycle(); smp = 1'b0;
        chk("tv_after_10", tv, 10);
        en = 1'b1; presc = 4'd3;
        run(40);
        smp = 1'b1; en = 1'b0; cycle(); smp = 1'b0;
        chk("tv_presc3", tv, 20);

        // Wrap and clear
        clr = 1'b1; cycle(); clr = 1'b0;
        en = 1'b1; presc = '0;
        run(254);
        run(2);
        chk("wrap_set", wrap, 1);
        smp = 1'b1; en = 1'b0; cycle(); smp = 1'b0;
        chk("tv_wrapped", tv, 0);
        clr = 1'b1; en = 1'b1; cycle(); clr = 1'b0; en = 1'b0;
        chk("wrap_cleared", wrap, 0);
        smp = 1'b1; cycle(); smp = 1'b0;
        chk("tv_clear_no_inc", tv, 0);

        // Channel 1 one-shot
        en = 1'b1; presc = '0; mask = '0;
        cmd1(C_START, 1, 4, 1'b0);
        run(4);
        chk("ch1_not_yet", pend[1], 0);
        run(1);
        chk("ch1_expired", pend[1], 1);
        chk("ch1_idle", act[1], 0);
        chk("ch1_irq_masked", irq, 0);
        mask = 3'b010;
        #1;
        chk("ch1_irq_unmask", irq, 1);
        cmd1(C_CLR, 1, 0, 1'b0);
        chk("ch1_cleared", pend[1], 0);

        // Channel 0 periodic
        mask = 3'b001;
        cmd1(C_START, 0, 2, 1'b1);
        run(3);
        chk("ch0_exp1", pend[0], 1);
        cmd1(C_CLR, 0, 0, 1'b0);
        chk("ch0_clr", pend[0], 0);
        run(1);
        cmd1(C_CLR, 0, 0, 1'b0);
        chk("ch0_set_wins", pend[0], 1);
        run(4);
        cmd1(C_STOP, 0, 0, 1'b0);
        run(10);
        chk("ch0_stopped", act[0], 0);

        // Channel 2 start on tick cycle, out-of-range select
        presc = 4'd1;
        run(1);
        cmd1(C_START, 2, 3, 1'b0);
        run(10);
        cmd1(C_START, 3, 2, 1'b1);
        run(3);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 59) == 0);
            smp = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 24) == 0) presc = PW'($urandom_range(0, 3));
            cmd  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            sel  = SW'($urandom_range(0, 3));
            load = DW'($urandom_range(0, 5));
            per  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) mask = NC'($urandom_range(0, 7));
            cycle();
        end

        // Asynchronous reset with pending flags set
        en = 1'b1; clr = 1'b0; smp = 1'b0; presc = '0; mask = 3'b111;
        cmd1(C_START, 0, 0, 1'b0);
        cmd1(C_START, 1, 0, 1'b0);
        cmd1(C_START, 2, 0, 1'b0);
        run(2);
        chk("pend_before_rst", pend, 3'b111);
        rst_n = 1'b0;
        #1;
        chk("arst_value", tv, 0);
        chk("arst_wrap", wrap, 0);
        chk("arst_active", act, 0);
        chk("arst_pend", pend, 0);
        chk("arst_irq", irq, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        run(12);
        chk("post_rst_irq", irq, 0);
        chk("sb_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
